// File: rtl/ddr2_host_pkg.sv
// Shared definitions for the DDR2 host command front end:
// command encodings, burst length helper, command FIFO entry layout, FSM states.
package ddr2_host_pkg;

    // Host address width carried in every command FIFO entry.
    localparam int HOST_ADDR_W = 25;

    // Host command encodings (0 and 7 are both NOP).
    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_SCR  = 3'd1;
    localparam logic [2:0] CMD_SCW  = 3'd2;
    localparam logic [2:0] CMD_BLR  = 3'd3;
    localparam logic [2:0] CMD_BLW  = 3'd4;
    localparam logic [2:0] CMD_ATR  = 3'd5;
    localparam logic [2:0] CMD_ATW  = 3'd6;
    localparam logic [2:0] CMD_NOP7 = 3'd7;

    // One command FIFO entry, head fields presented to the scheduler.
    typedef struct packed {
        logic [2:0]             cmd;
        logic [1:0]             sz;
        logic [2:0]             op;
        logic [HOST_ADDR_W-1:0] addr;
    } cmd_entry_t;

    // Front-end FSM states.
    typedef enum logic [1:0] {
        ST_WAIT_RDY = 2'd0,
        ST_ACCEPT   = 2'd1,
        ST_BLK_WR   = 2'd2
    } fe_state_t;

    // Block burst length in words: 8*(SZ+1) -> 8/16/24/32.
    function automatic logic [5:0] burst_len(input logic [1:0] sz);
        return {1'b0, sz, 3'b000} + 6'd8;
    endfunction

endpackage

// File: rtl/ddr2_host_frontend_if.sv
// Host-side and scheduler-side signals of the DDR2 host front end.
// slave = the front end itself, master = the host/scheduler driving it.
interface ddr2_host_frontend_if #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int DATA_DEPTH = 64
);
    localparam int FC_W = $clog2(DATA_DEPTH) + 1;

    // Host command port
    logic              READY;
    logic [2:0]        CMD;
    logic [1:0]        SZ;
    logic [2:0]        OP;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DIN;
    logic              NOTFULL;
    logic [FC_W-1:0]   FILLCOUNT;
    logic              BLK_BUSY;

    // Scheduler side
    logic              CQ_VALID;
    logic [2:0]        CQ_CMD;
    logic [1:0]        CQ_SZ;
    logic [2:0]        CQ_OP;
    logic [ADDR_W-1:0] CQ_ADDR;
    logic              CQ_POP;
    logic              DQ_VALID;
    logic [DATA_W-1:0] DQ_DATA;
    logic              DQ_POP;

    modport slave (
        input  READY, CMD, SZ, OP, ADDR, DIN, CQ_POP, DQ_POP,
        output NOTFULL, FILLCOUNT, BLK_BUSY,
               CQ_VALID, CQ_CMD, CQ_SZ, CQ_OP, CQ_ADDR,
               DQ_VALID, DQ_DATA
    );

    modport master (
        output READY, CMD, SZ, OP, ADDR, DIN, CQ_POP, DQ_POP,
        input  NOTFULL, FILLCOUNT, BLK_BUSY,
               CQ_VALID, CQ_CMD, CQ_SZ, CQ_OP, CQ_ADDR,
               DQ_VALID, DQ_DATA
    );

endinterface

// File: rtl/ddr2_sync_fifo.sv
// Single-clock FIFO with registered first-word-fall-through head and
// occupancy count. A pushed word reaches the head one cycle after its push.
// Pops on an empty FIFO and pushes on a full FIFO are dropped.
module ddr2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic [CW-1:0]    o_count
);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_do_push;
    logic             w_do_pop;
    logic [AW-1:0]    w_rd_next;
    logic [CW-1:0]    w_count_next;

    assign w_do_push    = i_push && (r_count != DEPTH_C);
    assign w_do_pop     = i_pop  && (r_count != '0);
    assign w_rd_next    = r_rd_ptr + AW'(w_do_pop);
    assign w_count_next = r_count + CW'(w_do_push) - CW'(w_do_pop);

    // Storage write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers, count and the registered head; the incoming word is forwarded
    // to the head when it becomes the oldest entry in the same cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            if (w_count_next != '0) begin
                if (w_do_push && (w_rd_next == r_wr_ptr)) begin
                    r_head <= i_din;
                end else begin
                    r_head <= r_mem[w_rd_next];
                end
            end
        end
    end

    assign o_head  = r_head;
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/ddr2_host_frontend.sv
// Host command front end of the DDR2 controller: accepts host commands under
// NOTFULL/FILLCOUNT back-pressure, queues commands and write data into two
// FIFOs for the downstream scheduler, and sequences block-write data bursts.
module ddr2_host_frontend
    import ddr2_host_pkg::*;
#(
    parameter int ADDR_W     = HOST_ADDR_W,
    parameter int DATA_W     = 16,
    parameter int CMD_DEPTH  = 16,
    parameter int DATA_DEPTH = 64
) (
    input  logic CLK,
    input  logic RESET,
    ddr2_host_frontend_if.slave bus
);
    localparam int CCW = $clog2(CMD_DEPTH) + 1;
    localparam int DCW = $clog2(DATA_DEPTH) + 1;

    fe_state_t   r_state;
    logic [4:0]  r_remaining;
    logic        r_blk_busy;

    logic [CCW-1:0]    w_cmd_count;
    logic [DCW-1:0]    w_data_count;
    logic              w_cspace;
    logic              w_dspace;
    logic              w_cmd_push;
    logic              w_data_push;
    logic              w_blw_start;
    cmd_entry_t        w_cmd_in;
    cmd_entry_t        w_cmd_head;
    logic              w_cmd_valid;
    logic [DATA_W-1:0] w_data_head;
    logic              w_data_valid;

    // Space flags come from registered counts only, so a pop frees space
    // one cycle later rather than combinationally.
    assign w_cspace = (w_cmd_count < CCW'(CMD_DEPTH));
    assign w_dspace = (w_data_count <= DCW'(DATA_DEPTH - 1));

    assign w_cmd_in = '{cmd: bus.CMD, sz: bus.SZ, op: bus.OP, addr: bus.ADDR};

    // Accept decision for the current cycle: which FIFOs receive a push.
    always_comb begin
        w_cmd_push  = 1'b0;
        w_data_push = 1'b0;
        w_blw_start = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                case (bus.CMD)
                    CMD_SCR, CMD_BLR: begin
                        w_cmd_push = w_cspace;
                    end
                    CMD_SCW, CMD_ATR, CMD_ATW: begin
                        w_cmd_push  = w_cspace && w_dspace;
                        w_data_push = w_cspace && w_dspace;
                    end
                    CMD_BLW: begin
                        w_cmd_push  = w_cspace && w_dspace;
                        w_data_push = w_cspace && w_dspace;
                        w_blw_start = w_cspace && w_dspace;
                    end
                    default: ;
                endcase
            end
            ST_BLK_WR: begin
                w_data_push = w_dspace;
            end
            default: ;
        endcase
    end

    // Front-end FSM: wait for READY once, accept commands, run BLW data bursts.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_WAIT_RDY;
            r_remaining <= '0;
            r_blk_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_RDY: begin
                    if (bus.READY) begin
                        r_state <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (w_blw_start) begin
                        r_remaining <= 5'(burst_len(bus.SZ) - 6'd1);
                        r_state     <= ST_BLK_WR;
                        r_blk_busy  <= 1'b1;
                    end
                end
                ST_BLK_WR: begin
                    if (w_dspace) begin
                        r_remaining <= r_remaining - 5'd1;
                        if (r_remaining == 5'd1) begin
                            r_state    <= ST_ACCEPT;
                            r_blk_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_WAIT_RDY;
                end
            endcase
        end
    end

    ddr2_sync_fifo #(
        .WIDTH ($bits(cmd_entry_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (CLK),
        .srst    (RESET),
        .i_push  (w_cmd_push),
        .i_din   (w_cmd_in),
        .i_pop   (bus.CQ_POP),
        .o_head  (w_cmd_head),
        .o_valid (w_cmd_valid),
        .o_count (w_cmd_count)
    );

    ddr2_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DATA_DEPTH)
    ) u_data_fifo (
        .clk     (CLK),
        .srst    (RESET),
        .i_push  (w_data_push),
        .i_din   (bus.DIN),
        .i_pop   (bus.DQ_POP),
        .o_head  (w_data_head),
        .o_valid (w_data_valid),
        .o_count (w_data_count)
    );

    assign bus.NOTFULL   = w_cspace;
    assign bus.FILLCOUNT = w_data_count;
    assign bus.BLK_BUSY  = r_blk_busy;
    assign bus.CQ_VALID  = w_cmd_valid;
    assign bus.CQ_CMD    = w_cmd_head.cmd;
    assign bus.CQ_SZ     = w_cmd_head.sz;
    assign bus.CQ_OP     = w_cmd_head.op;
    assign bus.CQ_ADDR   = w_cmd_head.addr;
    assign bus.DQ_VALID  = w_data_valid;
    assign bus.DQ_DATA   = w_data_head;

endmodule

// File: tb/tb_ddr2_host_frontend.sv
// Directed bench for ddr2_host_frontend: a table of single-cycle vectors
// followed by hand-written block-write, back-pressure and reset sequences.
module tb_ddr2_host_frontend;
    localparam int ADDR_W     = 25;
    localparam int DATA_W     = 16;
    localparam int DATA_DEPTH = 64;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ddr2_host_frontend_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DATA_DEPTH(DATA_DEPTH)
    ) bus ();

    ddr2_host_frontend #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(16), .DATA_DEPTH(DATA_DEPTH)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [1:0]  sz;
        logic [2:0]  op;
        logic [24:0] addr;
        logic [15:0] din;
        logic        cq_pop;
        logic        dq_pop;
        logic        e_notfull;
        logic [6:0]  e_fill;
        logic        e_cqv;
        logic [2:0]  e_cmd;
        logic [1:0]  e_sz;
        logic [2:0]  e_op;
        logic [24:0] e_addr;
        logic        e_dqv;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.CMD    = 3'd0;
        bus.SZ     = 2'd0;
        bus.OP     = 3'd0;
        bus.ADDR   = '0;
        bus.DIN    = '0;
        bus.CQ_POP = 1'b0;
        bus.DQ_POP = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        logic [15:0] n;
        logic [15:0] exp_d;

        // cmd sz op addr din cqpop dqpop | notfull fill cqv cmd sz op addr dqv data
        vecs[0] = '{3'd2, 2'd0, 3'd0, 25'h0008F7A, 16'hFACE, 1'b0, 1'b0,
                    1'b1, 7'd1, 1'b1, 3'd2, 2'd0, 3'd0, 25'h0008F7A, 1'b1, 16'hFACE};
        vecs[1] = '{3'd7, 2'd3, 3'd7, 25'h1FFFFFF, 16'h0000, 1'b0, 1'b0,
                    1'b1, 7'd1, 1'b1, 3'd2, 2'd0, 3'd0, 25'h0008F7A, 1'b1, 16'hFACE};
        vecs[2] = '{3'd1, 2'd2, 3'd1, 25'h002E0B9, 16'h1111, 1'b1, 1'b1,
                    1'b1, 7'd0, 1'b1, 3'd1, 2'd2, 3'd1, 25'h002E0B9, 1'b0, 16'h0000};
        vecs[3] = '{3'd0, 2'd0, 3'd0, 25'h0000000, 16'h0000, 1'b1, 1'b0,
                    1'b1, 7'd0, 1'b0, 3'd0, 2'd0, 3'd0, 25'h0000000, 1'b0, 16'h0000};
        vecs[4] = '{3'd5, 2'd0, 3'd3, 25'h1ABCDEF, 16'h1234, 1'b0, 1'b0,
                    1'b1, 7'd1, 1'b1, 3'd5, 2'd0, 3'd3, 25'h1ABCDEF, 1'b1, 16'h1234};
        vecs[5] = '{3'd3, 2'd1, 3'd0, 25'h0000100, 16'h9999, 1'b0, 1'b0,
                    1'b1, 7'd1, 1'b1, 3'd5, 2'd0, 3'd3, 25'h1ABCDEF, 1'b1, 16'h1234};
        vecs[6] = '{3'd6, 2'd0, 3'd5, 25'h0001234, 16'hBEEF, 1'b0, 1'b1,
                    1'b1, 7'd1, 1'b1, 3'd5, 2'd0, 3'd3, 25'h1ABCDEF, 1'b1, 16'hBEEF};
        vecs[7] = '{3'd0, 2'd0, 3'd0, 25'h0000000, 16'h0000, 1'b1, 1'b1,
                    1'b1, 7'd0, 1'b1, 3'd3, 2'd1, 3'd0, 25'h0000100, 1'b0, 16'h0000};
        vecs[8] = '{3'd0, 2'd0, 3'd0, 25'h0000000, 16'h0000, 1'b1, 1'b0,
                    1'b1, 7'd0, 1'b1, 3'd6, 2'd0, 3'd5, 25'h0001234, 1'b0, 16'h0000};
        vecs[9] = '{3'd0, 2'd0, 3'd0, 25'h0000000, 16'h0000, 1'b1, 1'b0,
                    1'b1, 7'd0, 1'b0, 3'd0, 2'd0, 3'd0, 25'h0000000, 1'b0, 16'h0000};

        // Reset state
        rst = 1'b1;
        bus.READY = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_notfull",  32'(bus.NOTFULL),   32'd1);
        chk("rst_fill",     32'(bus.FILLCOUNT), 32'd0);
        chk("rst_cqv",      32'(bus.CQ_VALID),  32'd0);
        chk("rst_dqv",      32'(bus.DQ_VALID),  32'd0);
        chk("rst_busy",     32'(bus.BLK_BUSY),  32'd0);
        chk("rst_cq_addr",  32'(bus.CQ_ADDR),   32'd0);
        chk("rst_dq_data",  32'(bus.DQ_DATA),   32'd0);
        $display("reset released");

        // Commands before READY are ignored, as is the one on the READY edge
        bus.CMD  = 3'd1;
        bus.ADDR = 25'h002E0B9;
        tick();
        tick();
        chk("pre_ready_cqv", 32'(bus.CQ_VALID), 32'd0);
        bus.READY = 1'b1;
        tick();
        chk("ready_edge_cqv", 32'(bus.CQ_VALID), 32'd0);
        $display("READY seen");

        // READY dropped for the whole table: acceptance must be sticky
        bus.READY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.CMD    = vecs[i].cmd;
            bus.SZ     = vecs[i].sz;
            bus.OP     = vecs[i].op;
            bus.ADDR   = vecs[i].addr;
            bus.DIN    = vecs[i].din;
            bus.CQ_POP = vecs[i].cq_pop;
            bus.DQ_POP = vecs[i].dq_pop;
            tick();
            $display("vec %0d cmd=%0d addr=%h din=%h cq_pop=%0d dq_pop=%0d fill=%0d",
                     i, vecs[i].cmd, vecs[i].addr, vecs[i].din, vecs[i].cq_pop,
                     vecs[i].dq_pop, bus.FILLCOUNT);
            chk($sformatf("v%0d_notfull", i), 32'(bus.NOTFULL),   32'(vecs[i].e_notfull));
            chk($sformatf("v%0d_fill", i),    32'(bus.FILLCOUNT), 32'(vecs[i].e_fill));
            chk($sformatf("v%0d_cqv", i),     32'(bus.CQ_VALID),  32'(vecs[i].e_cqv));
            chk($sformatf("v%0d_dqv", i),     32'(bus.DQ_VALID),  32'(vecs[i].e_dqv));
            chk($sformatf("v%0d_busy", i),    32'(bus.BLK_BUSY),  32'd0);
            if (vecs[i].e_cqv) begin
                chk($sformatf("v%0d_cq_cmd", i),  32'(bus.CQ_CMD),  32'(vecs[i].e_cmd));
                chk($sformatf("v%0d_cq_sz", i),   32'(bus.CQ_SZ),   32'(vecs[i].e_sz));
                chk($sformatf("v%0d_cq_op", i),   32'(bus.CQ_OP),   32'(vecs[i].e_op));
                chk($sformatf("v%0d_cq_addr", i), 32'(bus.CQ_ADDR), 32'(vecs[i].e_addr));
            end
            if (vecs[i].e_dqv) begin
                chk($sformatf("v%0d_dq_data", i), 32'(bus.DQ_DATA), 32'(vecs[i].e_data));
            end
        end
        idle_inputs();

        // Block write SZ=1: 16 words, BLK_BUSY for 15 cycles, CMD ignored in burst
        bus.CMD  = 3'd4;
        bus.SZ   = 2'd1;
        bus.ADDR = 25'h0000400;
        bus.DIN  = 16'h0000;
        tick();
        busy_cnt = bus.BLK_BUSY ? 1 : 0;
        chk("blw_cq_cmd", 32'(bus.CQ_CMD), 32'd4);
        chk("blw_cq_sz",  32'(bus.CQ_SZ),  32'd1);
        chk("blw_fill1",  32'(bus.FILLCOUNT), 32'd1);
        for (int i = 1; i < 16; i++) begin
            bus.CMD = 3'd1;
            bus.DIN = 16'(i);
            tick();
            if (bus.BLK_BUSY) busy_cnt++;
        end
        idle_inputs();
        chk("blw_busy_cycles", 32'(busy_cnt), 32'd15);
        chk("blw_busy_end",    32'(bus.BLK_BUSY), 32'd0);
        chk("blw_fill16",      32'(bus.FILLCOUNT), 32'd16);
        $display("BLW SZ=1 burst done busy_cycles=%0d fill=%0d", busy_cnt, bus.FILLCOUNT);
        bus.CQ_POP = 1'b1;
        tick();
        bus.CQ_POP = 1'b0;
        chk("blw_one_cmd", 32'(bus.CQ_VALID), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("blw_dq%0d", i), 32'(bus.DQ_DATA), 32'(i));
            bus.DQ_POP = 1'b1;
            tick();
            bus.DQ_POP = 1'b0;
        end
        chk("blw_drained", 32'(bus.DQ_VALID), 32'd0);

        // Fill data FIFO to 64 with two SZ=3 bursts, then SCW back-pressure
        n = 16'h0000;
        for (int b = 0; b < 2; b++) begin
            bus.CMD  = 3'd4;
            bus.SZ   = 2'd3;
            bus.ADDR = 25'h0000800;
            bus.DIN  = n;
            n++;
            tick();
            bus.CMD = 3'd0;
            for (int i = 0; i < 31; i++) begin
                bus.DIN = n;
                n++;
                tick();
            end
        end
        chk("full_fill64",   32'(bus.FILLCOUNT), 32'd64);
        chk("full_busy",     32'(bus.BLK_BUSY),  32'd0);
        bus.CMD  = 3'd2;
        bus.ADDR = 25'h0000055;
        bus.DIN  = 16'hAAAA;
        tick();
        tick();
        chk("full_scw_held", 32'(bus.FILLCOUNT), 32'd64);
        bus.DQ_POP = 1'b1;
        tick();
        bus.DQ_POP = 1'b0;
        chk("full_pop63",    32'(bus.FILLCOUNT), 32'd63);
        tick();
        chk("full_scw_acc",  32'(bus.FILLCOUNT), 32'd64);
        idle_inputs();
        $display("data FIFO full sequence fill=%0d", bus.FILLCOUNT);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("full_cq_blw%0d", i), 32'(bus.CQ_CMD), 32'd4);
            chk($sformatf("full_cq_sz%0d", i),  32'(bus.CQ_SZ),  32'd3);
            bus.CQ_POP = 1'b1;
            tick();
            bus.CQ_POP = 1'b0;
        end
        chk("full_cq_scw",  32'(bus.CQ_CMD),  32'd2);
        chk("full_cq_addr", 32'(bus.CQ_ADDR), 32'h55);
        bus.CQ_POP = 1'b1;
        tick();
        bus.CQ_POP = 1'b0;
        chk("full_cq_empty", 32'(bus.CQ_VALID), 32'd0);
        for (int i = 0; i < 64; i++) begin
            exp_d = (i < 63) ? 16'(i + 1) : 16'hAAAA;
            chk($sformatf("full_dq%0d", i), 32'(bus.DQ_DATA), 32'(exp_d));
            bus.DQ_POP = 1'b1;
            tick();
            bus.DQ_POP = 1'b0;
        end
        chk("full_dq_empty", 32'(bus.FILLCOUNT), 32'd0);

        // Command FIFO full: 16 SCR, 17th dropped, push+pop at count 15
        for (int i = 0; i < 16; i++) begin
            bus.CMD  = 3'd1;
            bus.ADDR = 25'(32'h100 + i);
            tick();
        end
        chk("cq_full_notfull", 32'(bus.NOTFULL), 32'd0);
        chk("cq_full_fill",    32'(bus.FILLCOUNT), 32'd0);
        bus.ADDR = 25'h00001FF;
        tick();
        chk("cq_17th_notfull", 32'(bus.NOTFULL), 32'd0);
        bus.CMD    = 3'd0;
        bus.CQ_POP = 1'b1;
        tick();
        chk("cq_pop_notfull",  32'(bus.NOTFULL), 32'd1);
        bus.CMD  = 3'd1;
        bus.ADDR = 25'h0000177;
        tick();
        bus.CQ_POP = 1'b0;
        chk("cq_pushpop_15",   32'(bus.NOTFULL), 32'd1);
        bus.ADDR = 25'h0000178;
        tick();
        idle_inputs();
        chk("cq_refull",       32'(bus.NOTFULL), 32'd0);
        $display("command FIFO full sequence notfull=%0d", bus.NOTFULL);
        for (int i = 0; i < 16; i++) begin
            logic [24:0] exp_a;
            exp_a = (i < 14) ? 25'(32'h102 + i) : ((i == 14) ? 25'h0000177 : 25'h0000178);
            chk($sformatf("cq_drain%0d", i), 32'(bus.CQ_ADDR), 32'(exp_a));
            bus.CQ_POP = 1'b1;
            tick();
            bus.CQ_POP = 1'b0;
        end
        chk("cq_drained", 32'(bus.CQ_VALID), 32'd0);

        // Reset in the middle of a BLW SZ=0 burst, then re-wait for READY
        bus.READY = 1'b1;
        bus.CMD   = 3'd4;
        bus.SZ    = 2'd0;
        bus.DIN   = 16'hD000;
        tick();
        bus.CMD = 3'd0;
        for (int i = 1; i < 5; i++) begin
            bus.DIN = 16'(16'hD000 + i);
            tick();
        end
        chk("mid_busy", 32'(bus.BLK_BUSY),  32'd1);
        chk("mid_fill", 32'(bus.FILLCOUNT), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_fill",    32'(bus.FILLCOUNT), 32'd0);
        chk("mrst_cqv",     32'(bus.CQ_VALID),  32'd0);
        chk("mrst_dqv",     32'(bus.DQ_VALID),  32'd0);
        chk("mrst_busy",    32'(bus.BLK_BUSY),  32'd0);
        chk("mrst_notfull", 32'(bus.NOTFULL),   32'd1);
        $display("reset during burst");
        bus.READY = 1'b0;
        bus.CMD   = 3'd2;
        bus.ADDR  = 25'h0000321;
        bus.DIN   = 16'h0001;
        for (int i = 0; i < 3; i++) tick();
        chk("mrst_noready_fill", 32'(bus.FILLCOUNT), 32'd0);
        chk("mrst_noready_cqv",  32'(bus.CQ_VALID),  32'd0);
        bus.READY = 1'b1;
        tick();
        chk("mrst_ready_edge", 32'(bus.FILLCOUNT), 32'd0);
        tick();
        idle_inputs();
        chk("mrst_accept_fill", 32'(bus.FILLCOUNT), 32'd1);
        chk("mrst_accept_cmd",  32'(bus.CQ_CMD),    32'd2);
        chk("mrst_accept_data", 32'(bus.DQ_DATA),   32'h0001);
        $display("SCW accepted after READY re-seen");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
